dbus_write_buffer: RTL and testbench
====================================

Name: dbus_write_buffer

Overview:
- Posted-write buffer between the CPU data-bus SRAM port (nak-style handshake, the CPUBus sram slot) and master 0 of the SRAM data-bus arbiter.
- CPU stores complete in one cycle when buffer space exists; queued writes drain to the arbiter in order.
- Reads pass straight through only when the buffer is empty; otherwise they stall until it drains, so read-after-write ordering always holds.
- Adjacent stores to the same word coalesce into the tail entry.

Parameters:
DEPTH, 4, number of queued write entries (power of 2, >=2)
CNT_W, 3, width of occupancy count (must hold 0..DEPTH)

Ports:
clk  in  1  sole clock (CPU clock domain)
rstn  in  1  asynchronous active-low reset
up_stb  in  1  upstream request strobe
up_addr  in  32  upstream byte address (bits [1:0] ignored)
up_din  in  32  upstream write data
up_dm  in  4  byte write enables; 4'h0 = read, nonzero = write
up_dout  out  32  read data to CPU bus
up_nak  out  1  1 = request not completed this cycle
dn_stb  out  1  downstream request strobe to arbiter
dn_addr  out  32  downstream address
dn_dout  out  32  downstream write data
dn_dm  out  4  downstream byte enables (4'h0 for reads)
dn_din  in  32  downstream read data
dn_nak  in  1  downstream not-complete
wb_count  out  CNT_W  current number of queued entries
wb_empty  out  1  wb_count==0

Behaviour:
- Handshake, both sides: a transfer completes on a rising edge where stb=1 and nak=0. Read data is valid in the completing cycle. The requester holds addr/data/dm stable while nak=1.
- Storage: circular FIFO of {addr[31:2], data[31:0], dm[3:0]} with head/tail pointers and count. Pointers wrap modulo DEPTH.
- Downstream mux, combinational:
  - count>0: dn_stb=1 and dn_* = head entry.
  - count==0: dn_stb = up_stb & (up_dm==0), dn_addr=up_addr, dn_dm=0, dn_dout=0.
- Pop: head advances when count>0 and dn_nak=0.
- Upstream write (up_stb, up_dm!=0):
  - Coalesce: if count>=2 and up_addr[31:2]==tail entry addr, merge bytes into the tail entry (per byte where up_dm=1, take up_din). up_nak=0, count unchanged.
  - Otherwise, if count<DEPTH: push, up_nak=0.
  - Otherwise (full): up_nak=1.
  - Full is evaluated on the registered count; a same-cycle pop does not free space for that write.
  - No coalescing at count==1, because the tail is the head currently presented downstream.
- Upstream read (up_stb, up_dm==0):
  - count==0: up_nak=dn_nak, up_dout=dn_din.
  - count>0: up_nak=1, up_dout=0. No forwarding. The read issues downstream in the first cycle after count reaches 0.
- up_stb=0: up_nak=0, up_dout=0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A write pushed into an empty buffer is presented downstream from the next cycle, giving 1-cycle minimum write latency to the arbiter.
- Reset (rstn low, asynchronous): pointers=0, count=0, entries discarded, wb_empty=1, wb_count=0.
  - With up_stb=0: dn_stb=0, dn_addr/dn_dout=0, dn_dm=0, up_nak=0.
  - Reset mid-drain abandons the in-flight entry; the arbiter must be reset by the same rstn.
- Entry data regs need no reset; pointers and count do.

Test Plan:
- Four writes 0x100..0x10C, data 0xA0..A3, dm=F, dn_nak=0 -> each up_nak=0. dn_stb high from cycle after first write. Downstream sees 0x100,0x104,0x108,0x10C in order. wb_count returns to 0.
- dn_nak held 1, five writes to distinct addresses -> first four accepted (wb_count=4), fifth sees up_nak=1. Release dn_nak -> fifth accepted on the cycle after first pop; order preserved.
- dn_nak=1, write 0x200 data 0x11223344 dm=F, write 0x204 dm=F, then 0x204 data 0x000000AA dm=1 -> wb_count stays 2. Drained 0x204 carries merged byte0=AA, dm=F.
- Buffer holds 2 writes, read 0x300 issued -> up_nak=1 and no dn read until wb_empty. Read then completes with up_dout=dn_din (0xDEADBEEF) in the completing cycle.
- Empty buffer, read with dn_nak=1 for 3 cycles then 0 -> up_nak mirrors dn_nak; dn_dm=0 throughout.
- 3 entries queued, dn_nak=1, assert rstn=0 mid-cycle -> wb_count=0, dn_stb=0 immediately (up_stb=0); after release, no stale writes appear downstream.

Source files
------------

// File: rtl/dbus_write_buffer.sv
// Posted-write buffer between the CPU data-bus SRAM port and arbiter master 0.
// Stores retire in one cycle into a small FIFO; reads wait until the FIFO has drained.
module dbus_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             up_stb,
    input  logic [31:0]      up_addr,
    input  logic [31:0]      up_din,
    input  logic [3:0]       up_dm,
    output logic [31:0]      up_dout,
    output logic             up_nak,
    output logic             dn_stb,
    output logic [31:0]      dn_addr,
    output logic [31:0]      dn_dout,
    output logic [3:0]       dn_dm,
    input  logic [31:0]      dn_din,
    input  logic             dn_nak,
    output logic [CNT_W-1:0] wb_count,
    output logic             wb_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       dm_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;
    logic [CNT_W-1:0] count;

    logic             is_write;
    logic             is_read;
    logic             not_empty;
    logic             full;
    logic             coalesce;
    logic             push;
    logic             pop;

    // Coalescing needs at least two entries so the tail is never the head being presented.
    always_comb begin
        is_write  = up_stb && (up_dm != 4'h0);
        is_read   = up_stb && (up_dm == 4'h0);
        not_empty = (count != '0);
        full      = (count >= CNT_W'(DEPTH));
        tail_last = tail - PTR_W'(1);
        coalesce  = is_write && (count >= CNT_W'(2)) && (up_addr[31:2] == addr_q[tail_last]);
        push      = is_write && !coalesce && !full;
        pop       = not_empty && !dn_nak;
    end

    always_comb begin
        dn_stb  = 1'b0;
        dn_addr = 32'h0;
        dn_dout = 32'h0;
        dn_dm   = 4'h0;
        up_nak  = 1'b0;
        up_dout = 32'h0;
        if (not_empty) begin
            dn_stb  = 1'b1;
            dn_addr = {addr_q[head], 2'b00};
            dn_dout = data_q[head];
            dn_dm   = dm_q[head];
        end else begin
            dn_stb  = is_read;
            dn_addr = up_stb ? up_addr : 32'h0;
        end
        if (is_write) begin
            up_nak = !(coalesce || push);
        end else if (is_read) begin
            up_nak  = not_empty ? 1'b1 : dn_nak;
            up_dout = not_empty ? 32'h0 : dn_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never reset; only valid entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= up_addr[31:2];
            data_q[tail] <= up_din;
            dm_q[tail]   <= up_dm;
        end else if (coalesce) begin
            for (int b = 0; b < 4; b++) begin
                if (up_dm[b]) data_q[tail_last][8*b +: 8] <= up_din[8*b +: 8];
            end
            dm_q[tail_last] <= dm_q[tail_last] | up_dm;
        end
    end

    assign wb_count = count;
    assign wb_empty = (count == '0);

endmodule

// File: tb/tb_dbus_write_buffer.sv
// Bench for dbus_write_buffer: directed scenarios then random traffic, checked against a queue model.
module tb_dbus_write_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             up_stb;
    logic [31:0]      up_addr;
    logic [31:0]      up_din;
    logic [3:0]       up_dm;
    logic [31:0]      up_dout;
    logic             up_nak;
    logic             dn_stb;
    logic [31:0]      dn_addr;
    logic [31:0]      dn_dout;
    logic [3:0]       dn_dm;
    logic [31:0]      dn_din;
    logic             dn_nak;
    logic [CNT_W-1:0] wb_count;
    logic             wb_empty;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad = 0;
    logic last_exp_nak = 1'b0;

    always #5 clk = ~clk;

    dbus_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .up_stb(up_stb), .up_addr(up_addr), .up_din(up_din), .up_dm(up_dm),
        .up_dout(up_dout), .up_nak(up_nak),
        .dn_stb(dn_stb), .dn_addr(dn_addr), .dn_dout(dn_dout), .dn_dm(dn_dm),
        .dn_din(dn_din), .dn_nak(dn_nak),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Expected outputs come from the queue contents and the current request; the model then retires the cycle.
    task automatic checkOutput();
        int          n;
        logic        is_wr, is_rd, merge, accept, e_nak;
        logic [31:0] e_dout;
        ent_t        t;
        n      = mq.size();
        is_wr  = up_stb && (up_dm != 4'h0);
        is_rd  = up_stb && (up_dm == 4'h0);
        merge  = is_wr && (n >= 2) && (up_addr[31:2] == mq[n-1].a);
        accept = merge || (is_wr && n < DEPTH);
        e_nak  = !up_stb ? 1'b0 : is_wr ? !accept : ((n == 0) ? dn_nak : 1'b1);
        e_dout = (is_rd && n == 0) ? dn_din : 32'h0;
        check("wb_count", 32'(wb_count), 32'(n));
        check("wb_empty", 32'(wb_empty), 32'(n == 0));
        check("dn_stb",   32'(dn_stb),   (n > 0) ? 32'd1 : 32'(is_rd));
        check("dn_addr",  dn_addr, (n > 0) ? {mq[0].a, 2'b00} : (up_stb ? up_addr : 32'h0));
        check("dn_dout",  dn_dout, (n > 0) ? mq[0].d : 32'h0);
        check("dn_dm",    32'(dn_dm), (n > 0) ? 32'(mq[0].m) : 32'h0);
        check("up_nak",   32'(up_nak), 32'(e_nak));
        check("up_dout",  up_dout, e_dout);
        last_exp_nak = e_nak;
        if (merge) begin
            t = mq[n-1];
            for (int b = 0; b < 4; b++) if (up_dm[b]) t.d[8*b +: 8] = up_din[8*b +: 8];
            t.m = t.m | up_dm;
            mq[n-1] = t;
        end else if (accept) begin
            t.a = up_addr[31:2];
            t.d = up_din;
            t.m = up_dm;
            mq.push_back(t);
        end
        if (n > 0 && !dn_nak) void'(mq.pop_front());
    endtask

    task automatic applyStimulus(input logic stb, input logic [31:0] addr, input logic [31:0] din,
                                 input logic [3:0] dm, input logic nak, input logic [31:0] ddin);
        up_stb  = stb;
        up_addr = addr;
        up_din  = din;
        up_dm   = dm;
        dn_nak  = nak;
        dn_din  = ddin;
        #2;
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (mq.size() != 0 && k < budget) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
            k++;
        end
        check("drain_done", 32'(wb_empty), 32'd1);
    endtask

    initial begin
        logic        r_stb;
        logic [31:0] r_addr, r_din;
        logic [3:0]  r_dm;
        int          k;

        rstn = 1'b0;
        up_stb = 1'b0; up_addr = 32'h0; up_din = 32'h0; up_dm = 4'h0;
        dn_nak = 1'b0; dn_din = 32'h0;
        #3;
        check("rst_count", 32'(wb_count), 32'd0);
        check("rst_empty", 32'(wb_empty), 32'd1);
        check("rst_dn_stb", 32'(dn_stb), 32'd0);
        check("rst_up_nak", 32'(up_nak), 32'd0);
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] four streaming writes");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0);
        drain(8);

        $display("[TB] fill to full with downstream stalled");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h400 + 32'(4*i), 32'hB0 + 32'(i), 4'hF, 1'b1, 32'h0);
        check("full_count", 32'(wb_count), 32'd4);
        k = 0;
        while (last_exp_nak && k < 6) begin
            applyStimulus(1'b1, 32'h410, 32'hB4, 4'hF, 1'b0, 32'h0);
            k++;
        end
        check("fifth_accepted", 32'(last_exp_nak), 32'd0);
        drain(8);

        $display("[TB] coalesce into tail");
        applyStimulus(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h204, 32'h55667788, 4'hF, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h204, 32'h000000AA, 4'h1, 1'b1, 32'h0);
        check("merge_count", 32'(wb_count), 32'd2);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        check("merge_addr", dn_addr, 32'h204);
        check("merge_data", dn_dout, 32'h556677AA);
        check("merge_dm", 32'(dn_dm), 32'hF);
        drain(8);

        $display("[TB] read stalls behind queued writes");
        applyStimulus(1'b1, 32'h600, 32'h1, 4'hF, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h604, 32'h2, 4'hF, 1'b1, 32'h0);
        applyStimulus(1'b1, 32'h300, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
        k = 0;
        while (last_exp_nak && k < 8) begin
            applyStimulus(1'b1, 32'h300, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
            k++;
        end
        check("read_completed", 32'(last_exp_nak), 32'd0);
        check("read_drained_first", 32'(k), 32'd3);

        $display("[TB] read on empty buffer with downstream stall");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h700, 32'h0, 4'h0, 1'b1, 32'h12345678);
        applyStimulus(1'b1, 32'h700, 32'h0, 4'h0, 1'b0, 32'h12345678);

        $display("[TB] asynchronous reset mid-drain");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h800 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, 1'b1, 32'h0);
        up_stb = 1'b0; up_dm = 4'h0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_count", 32'(wb_count), 32'd0);
        check("mid_rst_dn_stb", 32'(dn_stb), 32'd0);
        check("mid_rst_empty", 32'(wb_empty), 32'd1);
        mq.delete();
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

        $display("[TB] random traffic");
        r_stb = 1'b0; r_addr = 32'h0; r_din = 32'h0; r_dm = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (!(r_stb && last_exp_nak)) begin
                r_stb  = ($urandom_range(0, 3) != 0);
                r_addr = 32'h500 + 32'(4 * $urandom_range(0, 3));
                r_din  = $urandom;
                r_dm   = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            applyStimulus(r_stb, r_addr, r_din, r_dm, ($urandom_range(0, 2) == 0), $urandom);
        end
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
